// File: rtl/sys_arr_pkg.sv
// Shared types for the systolic array control path.
package sys_arr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DRAIN,
    LOAD_W,
    WAIT_SPACE,
    STREAM
  } seq_state_t;

endpackage

// File: rtl/seq_row_issue.sv
// Registers one accepted stream row onto the array bus: enable pulse, row index and row data.
module seq_row_issue #(
  parameter int unsigned NE = 1,
  parameter int unsigned RW = 64,
  parameter int unsigned IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NE-1:0] fire,
  input  logic [IW-1:0] idx,
  input  logic [RW-1:0] data,
  output logic [NE-1:0] en,
  output logic [IW-1:0] row,
  output logic [RW-1:0] row_data
);

  // Enables pulse for one cycle; index/data hold until the next accepted row.
  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= '0;
      row      <= '0;
      row_data <= '0;
    end else begin
      en <= fire;
      if (|fire) begin
        row      <= idx;
        row_data <= data;
      end
    end
  end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Sequences GEMM tiles (weights, inputs, partial sums) onto the systolic array bus and retires outputs.
module systolic_array_sequencer
  import sys_arr_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic                 cmd_reuse_w,
  output logic                 cmd_ready,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DW*N-1:0]      w_data,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [DW*N-1:0]      i_data,
  input  logic                 p_valid,
  output logic                 p_ready,
  input  logic [DW*N-1:0]      p_data,
  output logic                 weight_en,
  output logic                 input_en,
  output logic                 partial_en,
  output logic [$clog2(N)-1:0] row_in_en,
  output logic [$clog2(N)-1:0] row_ps_en,
  output logic [DW*N-1:0]      array_in,
  output logic [DW*N-1:0]      array_in_partials,
  input  logic                 drained,
  input  logic                 fifo_has_space,
  input  logic                 out_en,
  input  logic [$clog2(N)-1:0] row_out,
  output logic                 gemm_done,
  output logic                 busy,
  output logic                 err_row_order
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned RW = DW * N;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  seq_state_t    state;
  logic [CW-1:0] wcnt, icnt, pcnt, ocnt;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] icnt_nx, pcnt_nx;
  logic          w_fire, i_fire, p_fire;
  logic          issue_c, retire_c;
  logic [IW-1:0] wi_idx;
  logic [RW-1:0] wi_data;

  // Readies depend only on state and counters, never on the valids.
  assign cmd_ready = (state == IDLE) && (outstanding < OW'(MAX_OUT));
  assign w_ready   = (state == LOAD_W);
  assign i_ready   = (state == STREAM) && (icnt < CW'(N));
  assign p_ready   = (state == STREAM) && (pcnt < CW'(N));

  assign w_fire   = w_valid && w_ready;
  assign i_fire   = i_valid && i_ready;
  assign p_fire   = p_valid && p_ready;
  assign icnt_nx  = icnt + CW'(i_fire);
  assign pcnt_nx  = pcnt + CW'(p_fire);
  assign issue_c  = (state == STREAM) && (icnt_nx == CW'(N)) && (pcnt_nx == CW'(N));
  assign retire_c = out_en && (outstanding != '0) && (ocnt == CW'(N - 1));
  assign busy     = (state != IDLE) || (outstanding != '0);

  // Weight and input rows never overlap in time, so they share one bus stage.
  assign wi_idx  = w_fire ? wcnt[IW-1:0] : icnt[IW-1:0];
  assign wi_data = w_fire ? w_data : i_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      icnt  <= '0;
      pcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) state <= cmd_reuse_w ? WAIT_SPACE : WAIT_DRAIN;
        end
        // Weights may only be replaced once every in-flight GEMM has left the array.
        WAIT_DRAIN: begin
          if (drained && (outstanding == '0)) begin
            state <= LOAD_W;
            wcnt  <= '0;
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            wcnt <= wcnt + CW'(1);
            if (wcnt == CW'(N - 1)) state <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (fifo_has_space && (outstanding < OW'(MAX_OUT))) begin
            state <= STREAM;
            icnt  <= '0;
            pcnt  <= '0;
          end
        end
        STREAM: begin
          icnt <= icnt_nx;
          pcnt <= pcnt_nx;
          if (issue_c) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output-row tracking: retires the oldest GEMM on its last row, flags out-of-order rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      ocnt          <= '0;
      outstanding   <= '0;
      gemm_done     <= 1'b0;
      err_row_order <= 1'b0;
    end else begin
      gemm_done   <= retire_c;
      outstanding <= outstanding + OW'(issue_c) - OW'(retire_c);
      if (out_en) begin
        if (outstanding == '0) begin
          err_row_order <= 1'b1;
        end else begin
          if (row_out != ocnt[IW-1:0]) err_row_order <= 1'b1;
          ocnt <= (ocnt == CW'(N - 1)) ? '0 : ocnt + CW'(1);
        end
      end
    end
  end

  seq_row_issue #(.NE(2), .RW(RW), .IW(IW)) u_wi_issue (
    .clk      (clk),
    .rst      (rst),
    .fire     ({i_fire, w_fire}),
    .idx      (wi_idx),
    .data     (wi_data),
    .en       ({input_en, weight_en}),
    .row      (row_in_en),
    .row_data (array_in)
  );

  seq_row_issue #(.NE(1), .RW(RW), .IW(IW)) u_p_issue (
    .clk      (clk),
    .rst      (rst),
    .fire     (p_fire),
    .idx      (pcnt[IW-1:0]),
    .data     (p_data),
    .en       (partial_en),
    .row      (row_ps_en),
    .row_data (array_in_partials)
  );

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Randomized-stream bench for systolic_array_sequencer against a tile/row-count scoreboard model.
module tb_systolic_array_sequencer;

  localparam int unsigned N       = 4;
  localparam int unsigned DW      = 16;
  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned IW      = 2;
  localparam int unsigned RW      = DW * N;

  logic          clk, rst;
  logic          cmd_valid, cmd_reuse_w, cmd_ready;
  logic          w_valid, w_ready, i_valid, i_ready, p_valid, p_ready;
  logic [RW-1:0] w_data, i_data, p_data;
  logic          weight_en, input_en, partial_en;
  logic [IW-1:0] row_in_en, row_ps_en, row_out;
  logic [RW-1:0] array_in, array_in_partials;
  logic          drained, fifo_has_space, out_en;
  logic          gemm_done, busy, err_row_order;

  systolic_array_sequencer #(.N(N), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_reuse_w(cmd_reuse_w), .cmd_ready(cmd_ready),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
    .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
    .row_in_en(row_in_en), .row_ps_en(row_ps_en),
    .array_in(array_in), .array_in_partials(array_in_partials),
    .drained(drained), .fifo_has_space(fifo_has_space),
    .out_en(out_en), .row_out(row_out),
    .gemm_done(gemm_done), .busy(busy), .err_row_order(err_row_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard model: rows are numbered per tile, a GEMM is issued once N inputs and N partials
  // have both been taken, and retires on the Nth in-order output row.
  int  wcnt_m, icnt_m, pcnt_m, ocnt_m, out_m;
  bit  err_m;
  int  w_seen, done_seen;
  bit  w_on, i_on, p_on;
  bit  w_took, i_took, p_took;

  logic          fw, fi, fp, r_s, oe_s;
  logic [IW-1:0] ro_s;
  logic [RW-1:0] dw, di, dp;

  initial begin
    wcnt_m = 0; icnt_m = 0; pcnt_m = 0; ocnt_m = 0; out_m = 0; err_m = 0;
    w_seen = 0; done_seen = 0;
    forever begin
      bit exp_done, retire, issue;
      @(negedge clk); #2;
      fw = w_valid && w_ready; fi = i_valid && i_ready; fp = p_valid && p_ready;
      dw = w_data; di = i_data; dp = p_data;
      r_s = rst; oe_s = out_en; ro_s = row_out;
      w_took = fw; i_took = fi; p_took = fp;
      if (!r_s && icnt_m == N) check_eq("i_ready_tile_full", 64'(i_ready), 64'(0));
      if (!r_s && pcnt_m == N) check_eq("p_ready_tile_full", 64'(p_ready), 64'(0));
      @(posedge clk); #1;
      if (weight_en) w_seen++;
      if (gemm_done) done_seen++;
      if (r_s) begin
        check_eq("rst_weight_en", 64'(weight_en), 64'(0));
        check_eq("rst_input_en", 64'(input_en), 64'(0));
        check_eq("rst_partial_en", 64'(partial_en), 64'(0));
        check_eq("rst_row_in_en", 64'(row_in_en), 64'(0));
        check_eq("rst_row_ps_en", 64'(row_ps_en), 64'(0));
        check_eq("rst_array_in", 64'(array_in), 64'(0));
        check_eq("rst_array_in_partials", 64'(array_in_partials), 64'(0));
        check_eq("rst_gemm_done", 64'(gemm_done), 64'(0));
        check_eq("rst_err", 64'(err_row_order), 64'(0));
        wcnt_m = 0; icnt_m = 0; pcnt_m = 0; ocnt_m = 0; out_m = 0; err_m = 0;
      end else begin
        check_eq("weight_en", 64'(weight_en), 64'(fw));
        check_eq("input_en", 64'(input_en), 64'(fi));
        check_eq("partial_en", 64'(partial_en), 64'(fp));
        if (fw) begin
          check_eq("w_row", 64'(row_in_en), 64'(wcnt_m));
          check_eq("w_data", 64'(array_in), 64'(dw));
          wcnt_m = (wcnt_m + 1) % N;
        end
        if (fi) begin
          check_eq("i_row", 64'(row_in_en), 64'(icnt_m));
          check_eq("i_data", 64'(array_in), 64'(di));
          icnt_m++;
        end
        if (fp) begin
          check_eq("p_row", 64'(row_ps_en), 64'(pcnt_m));
          check_eq("p_data", 64'(array_in_partials), 64'(dp));
          pcnt_m++;
        end
        exp_done = 0; retire = 0; issue = 0;
        if (oe_s) begin
          if (out_m == 0) err_m = 1;
          else begin
            if (int'(ro_s) != ocnt_m) err_m = 1;
            if (ocnt_m == N - 1) begin
              exp_done = 1; retire = 1; ocnt_m = 0;
            end else ocnt_m++;
          end
        end
        if (icnt_m == N && pcnt_m == N) begin
          issue = 1; icnt_m = 0; pcnt_m = 0;
        end
        out_m = out_m + int'(issue) - int'(retire);
        check_eq("gemm_done", 64'(gemm_done), 64'(exp_done));
        check_eq("err_row_order", 64'(err_row_order), 64'(err_m));
      end
    end
  end

  // Randomly-gapped row sources; a row is held until it is taken.
  always @(negedge clk) begin
    if (w_took || !w_valid) begin w_valid = w_on && ($urandom_range(0, 3) != 0); w_data = {$urandom, $urandom}; end
    if (i_took || !i_valid) begin i_valid = i_on && ($urandom_range(0, 3) != 0); i_data = {$urandom, $urandom}; end
    if (p_took || !p_valid) begin p_valid = p_on && ($urandom_range(0, 3) != 0); p_data = {$urandom, $urandom}; end
  end

  task automatic issue_cmd(input bit reuse, input string tag);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_reuse_w = reuse;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (cmd_ready) begin ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check_eq(tag, 64'(ok), 64'(1));
  endtask

  task automatic wait_issued(input int target, input string tag);
    bit ok = 0;
    for (int k = 0; k < 500; k++) begin
      if (out_m == target) begin ok = 1; break; end
      @(negedge clk);
    end
    check_eq(tag, 64'(ok), 64'(1));
  endtask

  task automatic out_row(input int row);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    out_en = 1'b1; row_out = IW'(row);
    @(negedge clk);
    out_en = 1'b0;
  endtask

  task automatic retire_gemm();
    for (int j = 0; j < N; j++) out_row(j);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; cmd_valid = 0; cmd_reuse_w = 0; out_en = 0; row_out = '0;
    w_valid = 0; i_valid = 0; p_valid = 0; w_data = '0; i_data = '0; p_data = '0;
    w_on = 0; i_on = 0; p_on = 0; drained = 1; fifo_has_space = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check_eq("post_rst_busy", 64'(busy), 64'(0));
    w_on = 1; i_on = 1; p_on = 1;

    // Full GEMM with weight load.
    issue_cmd(0, "t2_cmd");
    wait_issued(1, "t2_issue");
    check_eq("t2_w_rows", 64'(w_seen), 64'(4));
    retire_gemm();
    repeat (2) @(negedge clk);
    check_eq("t2_done_cnt", 64'(done_seen), 64'(1));
    check_eq("t2_busy", 64'(busy), 64'(0));

    // FIFO backpressure after the weight load.
    fifo_has_space = 0;
    issue_cmd(0, "t3_cmd");
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (w_seen == 8) begin ok = 1; break; end
      @(negedge clk);
    end
    check_eq("t3_wload", 64'(ok), 64'(1));
    repeat (10) begin
      @(negedge clk);
      check_eq("t3_i_ready_held", 64'(i_ready), 64'(0));
      check_eq("t3_p_ready_held", 64'(p_ready), 64'(0));
    end
    fifo_has_space = 1;
    @(negedge clk);
    check_eq("t3_i_ready_start", 64'(i_ready), 64'(1));
    check_eq("t3_p_ready_start", 64'(p_ready), 64'(1));
    wait_issued(1, "t3_issue");
    retire_gemm();
    repeat (2) @(negedge clk);
    check_eq("t3_done_cnt", 64'(done_seen), 64'(2));

    // Outstanding limit.
    issue_cmd(1, "t4_c1");
    wait_issued(1, "t4_i1");
    issue_cmd(1, "t4_c2");
    wait_issued(2, "t4_i2");
    cmd_valid = 1; cmd_reuse_w = 1;
    repeat (5) begin
      @(negedge clk);
      check_eq("t4_cmd_held", 64'(cmd_ready), 64'(0));
    end
    retire_gemm();
    issue_cmd(1, "t4_c3");
    wait_issued(2, "t4_i3");
    retire_gemm();
    retire_gemm();
    repeat (2) @(negedge clk);
    check_eq("t4_done_cnt", 64'(done_seen), 64'(5));
    check_eq("t4_busy", 64'(busy), 64'(0));

    // Weight reload must wait for retire and drain.
    issue_cmd(1, "t5_c1");
    wait_issued(1, "t5_i1");
    drained = 0;
    issue_cmd(0, "t5_c2");
    repeat (6) begin
      @(negedge clk);
      check_eq("t5_w_ready_held", 64'(w_ready), 64'(0));
    end
    retire_gemm();
    repeat (3) begin
      @(negedge clk);
      check_eq("t5_w_ready_undrained", 64'(w_ready), 64'(0));
    end
    drained = 1;
    ok = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (w_ready) begin ok = 1; break; end
    end
    check_eq("t5_load_starts", 64'(ok), 64'(1));
    wait_issued(1, "t5_i2");
    retire_gemm();
    repeat (2) @(negedge clk);
    check_eq("t5_done_cnt", 64'(done_seen), 64'(7));

    // Out-of-order output row.
    issue_cmd(1, "t6_cmd");
    wait_issued(1, "t6_issue");
    out_row(2);
    @(negedge clk);
    check_eq("t6_err_set", 64'(err_row_order), 64'(1));
    out_row(1); out_row(2); out_row(3);
    repeat (2) @(negedge clk);
    check_eq("t6_err_sticky", 64'(err_row_order), 64'(1));
    check_eq("t6_done_cnt", 64'(done_seen), 64'(8));

    // Reset in the middle of a stream.
    p_on = 0;
    issue_cmd(1, "t1_cmd");
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (icnt_m >= 2) begin ok = 1; break; end
      @(negedge clk);
    end
    check_eq("t1_streaming", 64'(ok), 64'(1));
    check_eq("t1_busy", 64'(busy), 64'(1));
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    p_on = 1;
    @(negedge clk);
    check_eq("t1_cmd_ready", 64'(cmd_ready), 64'(1));
    check_eq("t1_busy_clr", 64'(busy), 64'(0));
    check_eq("t1_err_clr", 64'(err_row_order), 64'(0));

    // Random GEMMs.
    for (int g = 0; g < 6; g++) begin
      issue_cmd(1'($urandom_range(0, 1)), "rnd_cmd");
      wait_issued(1, "rnd_issue");
      retire_gemm();
    end
    repeat (3) @(negedge clk);
    check_eq("rnd_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
